// File: rtl/vexp_fsm_bf16.sv
// Per-lane VEXP sequencer: evaluates e^x with a 3rd-order Horner polynomial by issuing
// mul/add ops to the shared bf16 units and capturing results from the operand return bus.
module vexp_fsm_bf16 #(
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned ADD_LAT = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        valid_in,
    input  logic [15:0] operand,
    output logic [15:0] a,
    output logic        done,
    output logic        mul_valid_in,
    output logic [15:0] mul_a,
    output logic [15:0] mul_b,
    output logic        add_valid_in,
    output logic [15:0] add_a,
    output logic [15:0] add_b,
    output logic        sub
);

    localparam int unsigned W       = 16;
    localparam int unsigned STEP_W  = 3;
    localparam int unsigned MAX_LAT = (MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT;
    localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    localparam logic [W-1:0]      C3        = 16'h3E2B;
    localparam logic [W-1:0]      HALF      = 16'h3F00;
    localparam logic [W-1:0]      ONE       = 16'h3F80;
    localparam logic [STEP_W-1:0] LAST_STEP = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [STEP_W-1:0]  step_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [W-1:0]       x_q;
    logic [W-1:0]       acc_q;

    logic               load_issue_c;
    logic [STEP_W-1:0]  iss_step_c;
    logic [W-1:0]       iss_x_c;
    logic [W-1:0]       iss_acc_c;
    logic               iss_mul_c;
    logic [W-1:0]       iss_a_c;
    logic [W-1:0]       iss_b_c;

    // Operands of the op issued next: the step being entered, built from the freshly
    // captured value so the issue register sees the new accumulator in the same edge.
    always_comb begin
        load_issue_c = 1'b0;
        iss_step_c   = 3'(step_q + 3'd1);
        iss_x_c      = x_q;
        iss_acc_c    = operand;
        iss_mul_c    = 1'b0;
        iss_a_c      = '0;
        iss_b_c      = '0;

        if (state_q == S_IDLE) begin
            load_issue_c = valid_in;
            iss_step_c   = '0;
            iss_x_c      = operand;
            iss_acc_c    = '0;
        end else if (state_q == S_WAIT) begin
            load_issue_c = (cnt_q == '0) && (step_q != LAST_STEP);
        end

        iss_mul_c = ~iss_step_c[0];
        if (iss_mul_c) begin
            iss_a_c = (iss_step_c == 3'd0) ? iss_x_c : iss_acc_c;
            iss_b_c = (iss_step_c == 3'd0) ? C3 : iss_x_c;
        end else begin
            iss_a_c = iss_acc_c;
            iss_b_c = (iss_step_c == 3'd1) ? HALF : ONE;
        end
    end

    // Sequencer state, datapath registers and registered unit-interface outputs.
    always_ff @(posedge CLK) begin
        if (nRST) begin
            state_q      <= S_IDLE;
            step_q       <= '0;
            cnt_q        <= '0;
            x_q          <= '0;
            acc_q        <= '0;
            a            <= '0;
            done         <= 1'b0;
            mul_valid_in <= 1'b0;
            mul_a        <= '0;
            mul_b        <= '0;
            add_valid_in <= 1'b0;
            add_a        <= '0;
            add_b        <= '0;
            sub          <= 1'b0;
        end else begin
            done         <= 1'b0;
            mul_valid_in <= 1'b0;
            mul_a        <= '0;
            mul_b        <= '0;
            add_valid_in <= 1'b0;
            add_a        <= '0;
            add_b        <= '0;
            sub          <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (valid_in) begin
                        x_q     <= operand;
                        acc_q   <= '0;
                        step_q  <= '0;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt_q   <= step_q[0] ? CNT_W'(ADD_LAT - 1) : CNT_W'(MUL_LAT - 1);
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        acc_q <= operand;
                        if (step_q == LAST_STEP) begin
                            a       <= operand;
                            done    <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            step_q  <= iss_step_c;
                            state_q <= S_ISSUE;
                        end
                    end else begin
                        cnt_q <= CNT_W'(cnt_q - 1'b1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            if (load_issue_c) begin
                if (iss_mul_c) begin
                    mul_valid_in <= 1'b1;
                    mul_a        <= iss_a_c;
                    mul_b        <= iss_b_c;
                end else begin
                    add_valid_in <= 1'b1;
                    add_a        <= iss_a_c;
                    add_b        <= iss_b_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_vexp_fsm_bf16.sv
// Scoreboard bench for vexp_fsm_bf16: behavioural bf16 mul/add units with latency,
// expected issue/result events queued at stimulus time and checked by a monitor.
module tb_vexp_fsm_bf16;

    localparam int MUL_LAT = 2;
    localparam int ADD_LAT = 2;

    localparam logic [15:0] C3   = 16'h3E2B;
    localparam logic [15:0] HALF = 16'h3F00;
    localparam logic [15:0] ONE  = 16'h3F80;

    logic        CLK;
    logic        nRST;
    logic        valid_in;
    logic [15:0] operand;
    logic [15:0] a;
    logic        done;
    logic        mul_valid_in;
    logic [15:0] mul_a, mul_b;
    logic        add_valid_in;
    logic [15:0] add_a, add_b;
    logic        sub;

    vexp_fsm_bf16 #(.MUL_LAT(MUL_LAT), .ADD_LAT(ADD_LAT)) dut (
        .CLK(CLK), .nRST(nRST), .valid_in(valid_in), .operand(operand),
        .a(a), .done(done),
        .mul_valid_in(mul_valid_in), .mul_a(mul_a), .mul_b(mul_b),
        .add_valid_in(add_valid_in), .add_a(add_a), .add_b(add_b),
        .sub(sub)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // bf16 <-> real conversions (denormals flushed, result truncated)
    function automatic real bf2r(input logic [15:0] v);
        real m;
        int  e;
        if (v[14:7] == 8'd0) return 0.0;
        m = 1.0 + real'(v[6:0]) / 128.0;
        e = int'(v[14:7]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return v[15] ? -m : m;
    endfunction

    function automatic logic [15:0] r2bf(input real r);
        logic [63:0] b;
        int          e;
        if (r == 0.0) return 16'h0000;
        b = $realtobits(r);
        e = int'(b[62:52]) - 1023 + 127;
        if (e <= 0)   return {b[63], 15'h0000};
        if (e >= 255) return {b[63], 8'hFF, 7'h00};
        return {b[63], e[7:0], b[51:45]};
    endfunction

    function automatic logic [15:0] fmul(input logic [15:0] x, input logic [15:0] y);
        return r2bf(bf2r(x) * bf2r(y));
    endfunction

    function automatic logic [15:0] fadd(input logic [15:0] x, input logic [15:0] y);
        return r2bf(bf2r(x) + bf2r(y));
    endfunction

    // Shared-unit models: result appears on the return bus LAT cycles after the issue pulse.
    logic [16:0] mpipe [MUL_LAT];
    logic [16:0] apipe [ADD_LAT];
    logic [15:0] noise;
    logic        drv_x;
    logic [15:0] x_drv;
    logic        ret_v;
    logic [15:0] ret_d;

    always @(posedge CLK) begin
        mpipe[0] <= {mul_valid_in, fmul(mul_a, mul_b)};
        apipe[0] <= {add_valid_in, fadd(add_a, add_b)};
        for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
        for (int i = 1; i < ADD_LAT; i++) apipe[i] <= apipe[i-1];
        noise <= 16'($urandom);
    end

    always_comb begin
        ret_v = mpipe[MUL_LAT-1][16] | apipe[ADD_LAT-1][16];
        ret_d = mpipe[MUL_LAT-1][16] ? mpipe[MUL_LAT-1][15:0] : apipe[ADD_LAT-1][15:0];
    end

    assign operand = drv_x ? x_drv : (ret_v ? ret_d : noise);

    typedef struct {
        int          kind;   // 0 mul issue, 1 add issue, 2 done
        int          at;
        logic [15:0] opa;
        logic [15:0] opb;
    } ev_t;

    ev_t         q[$];
    logic [15:0] last_exp;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Horner evaluation of e^x, queueing every op the sequencer must issue and when.
    task automatic push_expect(input logic [15:0] x, input int c);
        logic [15:0] coef [3];
        logic [15:0] p;
        int          t;
        coef[0] = HALF; coef[1] = ONE; coef[2] = ONE;
        t = c + 1;
        q.push_back('{0, t, x, C3});
        p = fmul(x, C3);
        t += 1 + MUL_LAT;
        for (int i = 0; i < 3; i++) begin
            q.push_back('{1, t, p, coef[i]});
            p = fadd(p, coef[i]);
            t += 1 + ADD_LAT;
            if (i < 2) begin
                q.push_back('{0, t, p, x});
                p = fmul(p, x);
                t += 1 + MUL_LAT;
            end
        end
        q.push_back('{2, t, p, 16'h0000});
        last_exp = p;
    endtask

    always @(negedge CLK) begin
        ev_t e;
        int  kind;
        if (!nRST) begin
            chk("sub_zero", 64'(sub), 64'd0);
            chk("single_issue", 64'(mul_valid_in & add_valid_in), 64'd0);
            if (!mul_valid_in) chk("mul_idle_zero", 64'({mul_a, mul_b}), 64'd0);
            if (!add_valid_in) chk("add_idle_zero", 64'({add_a, add_b}), 64'd0);
            if (mul_valid_in || add_valid_in || done) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: got mul=%b add=%b done=%b expected none (cycle %0d)",
                             mul_valid_in, add_valid_in, done, cyc);
                end else begin
                    e    = q.pop_front();
                    kind = done ? 2 : (add_valid_in ? 1 : 0);
                    chk("event_kind", 64'(kind), 64'(e.kind));
                    chk("event_cycle", 64'(cyc), 64'(e.at));
                    if (e.kind == 0) begin
                        chk("mul_a", 64'(mul_a), 64'(e.opa));
                        chk("mul_b", 64'(mul_b), 64'(e.opb));
                    end else if (e.kind == 1) begin
                        chk("add_a", 64'(add_a), 64'(e.opa));
                        chk("add_b", 64'(add_b), 64'(e.opb));
                    end else begin
                        chk("result", 64'(a), 64'(e.opa));
                    end
                end
            end
        end
    end

    // One operation; optional busy valid_in poke and mid-operation reset (relative cycles, -1 = none).
    task automatic run_op(input logic [15:0] x, input int poke, input int abort);
        int c;
        #1;
        c = cyc;
        push_expect(x, c);
        valid_in = 1'b1;
        drv_x    = 1'b1;
        x_drv    = x;
        for (int i = 0; i < 60; i++) begin
            @(posedge CLK);
            #1;
            valid_in = 1'b0;
            drv_x    = 1'b0;
            nRST     = 1'b0;
            if (q.size() == 0) break;
            if (cyc - c == poke) begin
                valid_in = 1'b1;
                drv_x    = 1'b1;
                x_drv    = 16'($urandom);
            end
            if (cyc - c == abort) begin
                nRST = 1'b1;
                q.delete();
            end
        end
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: got %0d events pending expected 0 (cycle %0d)", q.size(), cyc);
            q.delete();
        end
    endtask

    function automatic logic [15:0] rand_x();
        real r;
        r = (real'($urandom_range(0, 3000)) - 1500.0) / 1000.0;
        return r2bf(r);
    endfunction

    initial begin
        int poke;
        nRST     = 1'b1;
        valid_in = 1'b1;
        drv_x    = 1'b1;
        x_drv    = 16'h3F80;

        // reset held with valid_in asserted: no issue, everything zero
        repeat (5) begin
            @(negedge CLK);
            chk("rst_ctrl", 64'({mul_valid_in, add_valid_in, done, sub}), 64'd0);
            chk("rst_data", {a, mul_a, mul_b, add_a | add_b}, 64'd0);
        end
        @(posedge CLK);
        #1;
        nRST     = 1'b0;
        valid_in = 1'b0;
        drv_x    = 1'b0;
        repeat (3) @(posedge CLK);

        run_op(16'h0000, -1, -1);
        chk("x0_result", 64'(a), 64'(16'h3F80));

        run_op(16'h3F80, -1, -1);
        run_op(16'h3FC0, -1, -1);
        run_op(16'hBF80, -1, -1);

        // busy valid_in in WAIT and in DONE must be ignored
        run_op(16'h3F00, 2, -1);
        run_op(16'h3E80, 19, -1);
        repeat (4) @(posedge CLK);
        #1;
        chk("a_hold", 64'(a), 64'(last_exp));

        // back-to-back random operations with random busy pokes off the capture cycles
        for (int n = 0; n < 10; n++) begin
            poke = 3 * int'($urandom_range(0, 6)) + int'($urandom_range(1, 2));
            run_op(rand_x(), (n % 2 == 0) ? poke : -1, -1);
        end

        // reset at cycle 8 aborts; no done, result cleared, next op completes
        run_op(16'h3FC0, -1, 8);
        repeat (25) begin
            @(negedge CLK);
            chk("abort_no_done", 64'(done), 64'd0);
        end
        chk("abort_a", 64'(a), 64'd0);
        run_op(16'h3F80, -1, -1);
        run_op(rand_x(), -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
